// File: rtl/beam_pkg.sv
// Shared constants and FSM state type for the 8-mic delay-and-sum beam path.
// The energy term width depends on the ENERGY_SQUARE_EN build macro:
// squared beam sum when defined, absolute beam sum otherwise.
package beam_pkg;

    localparam int PCM_W    = 19;
    localparam int NUM_MICS = 8;
    localparam int SUM_W    = 22;
    localparam int DSEL_W   = 5;

`ifdef ENERGY_SQUARE_EN
    localparam int TERM_W = 2 * SUM_W;
`else
    localparam int TERM_W = SUM_W;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        COMPARE,
        DONE
    } scan_state_e;

endpackage

// File: rtl/beam_summer.sv
// Beam former: sign-extending 8-input adder with a registered sum and
// valid strobe, plus the per-sample energy term derived from the
// registered sum. ENERGY_SQUARE_EN selects sum*sum instead of |sum|.
module beam_summer
    import beam_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [PCM_W-1:0]  pcm [NUM_MICS],
    output logic signed [SUM_W-1:0]  sum_out,
    output logic                     sum_valid,
    output logic [TERM_W-1:0]        term
);

    logic signed [SUM_W-1:0] sum_d, sum_q, total;
    logic                    valid_d, valid_q;

    // Add all channels at full beam width; the sum is only captured on a valid sample.
    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_MICS; i++) begin
            total = total + {{(SUM_W-PCM_W){pcm[i][PCM_W-1]}}, pcm[i]};
        end
        sum_d   = sample_valid ? total : sum_q;
        valid_d = sample_valid;
    end

    // Output register for the beam sum and its qualifying strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = valid_q;

`ifdef ENERGY_SQUARE_EN
    logic signed [TERM_W-1:0] sum_wide;

    // Square of the registered sum; the largest magnitude 2^21 squares to 2^42, well inside 44 bits.
    always_comb begin
        sum_wide = {{(TERM_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
        term     = $unsigned(sum_wide * sum_wide);
    end
`else
    // Magnitude of the registered sum; -2^21 negates to bit pattern 2^21, read as unsigned.
    always_comb begin
        term = sum_q[SUM_W-1] ? $unsigned(-sum_q) : $unsigned(sum_q);
    end
`endif

endmodule

// File: rtl/beam_steer_scanner.sv
// Closed-loop steering scanner: steps delay_select through every direction,
// discards SETTLE beam samples after each change, accumulates 2^WINDOW_LOG2
// energy terms, and keeps the strongest direction (lowest index wins ties).
// Build macro ENERGY_SQUARE_EN switches the energy term to the squared sum.
module beam_steer_scanner
    import beam_pkg::*;
#(
    parameter int NUM_DIRS    = 24,
    parameter int SETTLE      = 32,
    parameter int WINDOW_LOG2 = 8
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              sample_valid,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_0,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_1,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_2,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_3,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_4,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_5,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_6,
    input  logic signed [PCM_W-1:0]           delayed_pcm_data_7,
    output logic [DSEL_W-1:0]                 delay_select,
    output logic signed [SUM_W-1:0]           sum_out,
    output logic                              sum_valid,
    output logic                              busy,
    output logic                              done,
    output logic [DSEL_W-1:0]                 best_select,
    output logic [TERM_W+WINDOW_LOG2-1:0]     best_energy
);

    localparam int ACC_W   = TERM_W + WINDOW_LOG2;
    localparam int CNT_A   = WINDOW_LOG2 + 1;
    localparam int CNT_B   = $clog2(SETTLE + 1);
    localparam int CNT_W   = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'((1 << WINDOW_LOG2) - 1);
    localparam logic [DSEL_W-1:0] LAST_DIR    = DSEL_W'(NUM_DIRS - 1);

    logic signed [PCM_W-1:0] pcm [NUM_MICS];
    logic [TERM_W-1:0]       term;

    assign pcm = '{delayed_pcm_data_0, delayed_pcm_data_1, delayed_pcm_data_2,
                   delayed_pcm_data_3, delayed_pcm_data_4, delayed_pcm_data_5,
                   delayed_pcm_data_6, delayed_pcm_data_7};

    beam_summer u_summer (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .pcm          (pcm),
        .sum_out      (sum_out),
        .sum_valid    (sum_valid),
        .term         (term)
    );

    scan_state_e        state_d, state_q;
    logic [DSEL_W-1:0]  dir_d, dir_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [ACC_W-1:0]   acc_d, acc_q;
    logic [DSEL_W-1:0]  best_sel_d, best_sel_q;
    logic [ACC_W-1:0]   best_en_d, best_en_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;

    // Scan sequencing: settle, accumulate, compare per direction; outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        best_sel_d = best_sel_q;
        best_en_d  = best_en_q;
        case (state_q)
            beam_pkg::IDLE: begin
                if (start) begin
                    dir_d     = '0;
                    best_en_d = '0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = beam_pkg::SETTLE;
                end
            end
            beam_pkg::SETTLE: begin
                if (sum_valid) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = beam_pkg::ACCUM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            beam_pkg::ACCUM: begin
                if (sum_valid) begin
                    acc_d = acc_q + ACC_W'(term);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WINDOW_LAST) begin
                        state_d = beam_pkg::COMPARE;
                    end
                end
            end
            beam_pkg::COMPARE: begin
                if (dir_q == '0 || acc_q > best_en_q) begin
                    best_en_d  = acc_q;
                    best_sel_d = dir_q;
                end
                if (dir_q == LAST_DIR) begin
                    state_d = beam_pkg::DONE;
                end else begin
                    dir_d   = dir_q + 1'b1;
                    cnt_d   = '0;
                    state_d = beam_pkg::SETTLE;
                end
            end
            beam_pkg::DONE: begin
                state_d = beam_pkg::IDLE;
            end
            default: begin
                state_d = beam_pkg::IDLE;
            end
        endcase
        busy_d = (state_d != beam_pkg::IDLE);
        done_d = (state_d == beam_pkg::DONE);
    end

    // Scanner state register; reset returns every counter, accumulator and output to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= beam_pkg::IDLE;
            dir_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            best_sel_q <= '0;
            best_en_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            best_sel_q <= best_sel_d;
            best_en_q  <= best_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign delay_select = dir_q;
    assign best_select  = best_sel_q;
    assign best_energy  = best_en_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_beam_steer_scanner.sv
// Self-checking bench for beam_steer_scanner. Per-direction channel patterns
// feed the DUT through a behavioural delay stage; expected winners come from
// a direction-level energy model (window * term(sum of channels)).
// Honours ENERGY_SQUARE_EN for the energy term.
`timescale 1ns/1ps
module tb_beam_steer_scanner;

    localparam int NUM_DIRS    = 8;
    localparam int SETTLE      = 32;
    localparam int WINDOW_LOG2 = 8;
    localparam int WINDOW      = 1 << WINDOW_LOG2;
`ifdef ENERGY_SQUARE_EN
    localparam int ACC_W = 44 + WINDOW_LOG2;
`else
    localparam int ACC_W = 22 + WINDOW_LOG2;
`endif
    localparam int BUDGET = 40000;

    logic clk = 1'b0;
    logic rst, start, sample_valid;
    logic signed [18:0] pcm [8];
    logic [4:0]         delay_select, best_select;
    logic signed [21:0] sum_out;
    logic               sum_valid, busy, done;
    logic [ACC_W-1:0]   best_energy;

    int pat [NUM_DIRS][8];
    int valid_period;
    int valid_phase;
    int drv_idx;
    int done_count;
    int dir_count [32];
    int n_checks;
    int n_pass;

    always #5 clk = ~clk;

    beam_steer_scanner #(
        .NUM_DIRS    (NUM_DIRS),
        .SETTLE      (SETTLE),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .sample_valid       (sample_valid),
        .delayed_pcm_data_0 (pcm[0]),
        .delayed_pcm_data_1 (pcm[1]),
        .delayed_pcm_data_2 (pcm[2]),
        .delayed_pcm_data_3 (pcm[3]),
        .delayed_pcm_data_4 (pcm[4]),
        .delayed_pcm_data_5 (pcm[5]),
        .delayed_pcm_data_6 (pcm[6]),
        .delayed_pcm_data_7 (pcm[7]),
        .delay_select       (delay_select),
        .sum_out            (sum_out),
        .sum_valid          (sum_valid),
        .busy               (busy),
        .done               (done),
        .best_select        (best_select),
        .best_energy        (best_energy)
    );

    // Behavioural delay stage: channel data follows the selected direction's pattern.
    initial begin
        valid_phase  = 0;
        sample_valid = 1'b0;
        for (int ch = 0; ch < 8; ch++) pcm[ch] = '0;
        forever begin
            @(negedge clk);
            drv_idx = int'(delay_select);
            for (int ch = 0; ch < 8; ch++) begin
                pcm[ch] = (drv_idx < NUM_DIRS) ? 19'(pat[drv_idx][ch]) : '0;
            end
            sample_valid = (valid_phase == 0);
            valid_phase  = (valid_phase + 1 >= valid_period) ? 0 : valid_phase + 1;
        end
    end

    // Counts done pulses and beam samples seen per direction while a scan is busy.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_count++;
            if (busy === 1'b1 && sum_valid === 1'b1) dir_count[delay_select]++;
        end
    end

    function automatic longint term_of(input longint s);
`ifdef ENERGY_SQUARE_EN
        return s * s;
`else
        return (s < 0) ? -s : s;
`endif
    endfunction

    // Strongest direction of the current pattern table; strict > keeps the lowest index on ties.
    task automatic model_scan(output int exp_sel, output longint exp_en);
        longint s, e;
        exp_sel = 0;
        exp_en  = -1;
        for (int d = 0; d < NUM_DIRS; d++) begin
            s = 0;
            for (int ch = 0; ch < 8; ch++) s += pat[d][ch];
            e = term_of(s) * WINDOW;
            if (e > exp_en) begin
                exp_en  = e;
                exp_sel = d;
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int d = 0; d < NUM_DIRS; d++)
            for (int ch = 0; ch < 8; ch++) pat[d][ch] = v;
    endtask

    task automatic fill_steer(input int hot);
        for (int d = 0; d < NUM_DIRS; d++)
            for (int ch = 0; ch < 8; ch++)
                pat[d][ch] = (d == hot || ch % 2 == 0) ? 1000 : -1000;
    endtask

    task automatic clear_monitors();
        done_count = 0;
        for (int d = 0; d < 32; d++) dir_count[d] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        valid_period = 1;
        fill_const(0);
        repeat (3) @(negedge clk);
        n_checks++; if (delay_select !== 5'd0) $display("[TB] FAIL reset_delay_select: got %0d expected 0", delay_select); else n_pass++;
        n_checks++; if (sum_out !== 22'sd0) $display("[TB] FAIL reset_sum_out: got %0d expected 0", sum_out); else n_pass++;
        n_checks++; if (sum_valid !== 1'b0) $display("[TB] FAIL reset_sum_valid: got %b expected 0", sum_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (best_select !== 5'd0) $display("[TB] FAIL reset_best_select: got %0d expected 0", best_select); else n_pass++;
        n_checks++; if (best_energy !== '0) $display("[TB] FAIL reset_best_energy: got %0d expected 0", best_energy); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_uniform();
        bit to;
        int exp_sel;
        longint exp_en;
        fill_const(1000);
        valid_period = 1;
        clear_monitors();
        model_scan(exp_sel, exp_en);
        pulse_start();
        n_checks++; if (busy !== 1'b1 || delay_select !== 5'd0) $display("[TB] FAIL uniform_start: busy %b dsel %0d expected 1/0", busy, delay_select); else n_pass++;
        wait_done(to);
        n_checks++; if (to) $display("[TB] FAIL uniform_timeout: done not seen within %0d cycles", BUDGET); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL uniform_after_done: busy %b done %b expected 0/0", busy, done); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (done_count !== 1) $display("[TB] FAIL uniform_done_count: got %0d expected 1", done_count); else n_pass++;
        n_checks++; if (int'(best_select) !== exp_sel) $display("[TB] FAIL uniform_best_select: got %0d expected %0d", best_select, exp_sel); else n_pass++;
        n_checks++; if (longint'(best_energy) !== exp_en) $display("[TB] FAIL uniform_best_energy: got %0d expected %0d", best_energy, exp_en); else n_pass++;
    endtask

    task automatic test_steer(input int period, input string tag);
        bit to;
        int exp_sel;
        longint exp_en;
        fill_steer(5);
        valid_period = period;
        clear_monitors();
        model_scan(exp_sel, exp_en);
        pulse_start();
        wait_done(to);
        n_checks++; if (to) $display("[TB] FAIL %s_timeout: done not seen within %0d cycles", tag, BUDGET); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (int'(best_select) !== exp_sel) $display("[TB] FAIL %s_best_select: got %0d expected %0d", tag, best_select, exp_sel); else n_pass++;
        n_checks++; if (longint'(best_energy) !== exp_en) $display("[TB] FAIL %s_best_energy: got %0d expected %0d", tag, best_energy, exp_en); else n_pass++;
        if (period > 1) begin
            for (int d = 0; d < NUM_DIRS; d++) begin
                n_checks++; if (dir_count[d] !== SETTLE + WINDOW) $display("[TB] FAIL %s_samples_dir%0d: got %0d expected %0d", tag, d, dir_count[d], SETTLE + WINDOW); else n_pass++;
            end
        end
    endtask

    task automatic test_min_value();
        bit to;
        int exp_sel;
        longint exp_en;
        fill_const(-262144);
        valid_period = 1;
        clear_monitors();
        model_scan(exp_sel, exp_en);
        pulse_start();
        wait_done(to);
        n_checks++; if (to) $display("[TB] FAIL minval_timeout: done not seen within %0d cycles", BUDGET); else n_pass++;
        n_checks++; if (sum_out !== -22'sd2097152) $display("[TB] FAIL minval_sum_out: got %0d expected -2097152", sum_out); else n_pass++;
        n_checks++; if (int'(best_select) !== exp_sel) $display("[TB] FAIL minval_best_select: got %0d expected %0d", best_select, exp_sel); else n_pass++;
        n_checks++; if (longint'(best_energy) !== exp_en) $display("[TB] FAIL minval_best_energy: got %0d expected %0d", best_energy, exp_en); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        bit to, found;
        int exp_sel;
        longint exp_en;
        fill_steer(2);
        valid_period = 1;
        clear_monitors();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (delay_select === 5'd3) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) $display("[TB] FAIL rstmid_reach_dir3: delay_select never reached 3"); else n_pass++;
        repeat (80) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (delay_select !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || sum_valid !== 1'b0)
            $display("[TB] FAIL rstmid_ctrl: dsel %0d busy %b done %b sv %b expected all 0", delay_select, busy, done, sum_valid); else n_pass++;
        n_checks++; if (sum_out !== 22'sd0 || best_select !== 5'd0 || best_energy !== '0)
            $display("[TB] FAIL rstmid_data: sum %0d bsel %0d ben %0d expected all 0", sum_out, best_select, best_energy); else n_pass++;
        rst = 1'b0;
        repeat (300) @(negedge clk);
        n_checks++; if (done_count !== 0 || busy !== 1'b0) $display("[TB] FAIL rstmid_no_done: done_count %0d busy %b expected 0/0", done_count, busy); else n_pass++;
        model_scan(exp_sel, exp_en);
        pulse_start();
        n_checks++; if (busy !== 1'b1 || delay_select !== 5'd0) $display("[TB] FAIL rstmid_restart: busy %b dsel %0d expected 1/0", busy, delay_select); else n_pass++;
        wait_done(to);
        n_checks++; if (to) $display("[TB] FAIL rstmid_timeout: done not seen within %0d cycles", BUDGET); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (int'(best_select) !== exp_sel || longint'(best_energy) !== exp_en)
            $display("[TB] FAIL rstmid_result: got %0d/%0d expected %0d/%0d", best_select, best_energy, exp_sel, exp_en); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit to, found;
        int exp_sel;
        longint exp_en;
        fill_steer(6);
        valid_period = 1;
        clear_monitors();
        model_scan(exp_sel, exp_en);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (delay_select === 5'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) $display("[TB] FAIL b2b_reach_dir2: delay_select never reached 2"); else n_pass++;
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (100) @(negedge clk);
        pulse_start();
        n_checks++; if (delay_select !== 5'd2) $display("[TB] FAIL b2b_start_ignored: dsel %0d expected 2", delay_select); else n_pass++;
        wait_done(to);
        n_checks++; if (to) $display("[TB] FAIL b2b_timeout: done not seen within %0d cycles", BUDGET); else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_start_in_done: busy %b expected 0", busy); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (done_count !== 1 || busy !== 1'b0) $display("[TB] FAIL b2b_single_done: done_count %0d busy %b expected 1/0", done_count, busy); else n_pass++;
        n_checks++; if (int'(best_select) !== exp_sel || longint'(best_energy) !== exp_en)
            $display("[TB] FAIL b2b_result: got %0d/%0d expected %0d/%0d", best_select, best_energy, exp_sel, exp_en); else n_pass++;
    endtask

    task automatic test_random(input int iter);
        bit to;
        int exp_sel;
        longint exp_en;
        for (int d = 0; d < NUM_DIRS; d++)
            for (int ch = 0; ch < 8; ch++)
                pat[d][ch] = int'($urandom_range(0, 524287)) - 262144;
        valid_period = int'($urandom_range(1, 2));
        clear_monitors();
        model_scan(exp_sel, exp_en);
        pulse_start();
        wait_done(to);
        n_checks++; if (to) $display("[TB] FAIL rand%0d_timeout: done not seen within %0d cycles", iter, BUDGET); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (int'(best_select) !== exp_sel) $display("[TB] FAIL rand%0d_best_select: got %0d expected %0d", iter, best_select, exp_sel); else n_pass++;
        n_checks++; if (longint'(best_energy) !== exp_en) $display("[TB] FAIL rand%0d_best_energy: got %0d expected %0d", iter, best_energy, exp_en); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_monitors();
        test_reset();
        test_uniform();
        test_steer(1, "steer");
        test_min_value();
        test_steer(7, "sparse");
        test_reset_mid_scan();
        test_back_to_back();
        for (int i = 0; i < 2; i++) test_random(i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
